pulse_period_monitor: RTL and testbench

Receive-side checker for periodic single-cycle strobes such as the ones produced by our tick generators. It measures the interval between successive strobes and compares it against the expected period. After a run of consecutive good intervals it declares lock, and it flags any deviation. It sits downstream of a strobe source and qualifies that source for the logic that consumes its ticks.

---
 rtl/pulse_period_monitor.sv | 147 ++++++++++++++
 tb/tb_pulse_period_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_monitor.sv
// Strobe period checker: measures strobe spacing, tracks lock, flags deviations.
// Optional strobe-loss timeout is compiled in with PULSE_PERIOD_MONITOR_TIMEOUT_EN.
module pulse_period_monitor #(
    parameter int DELAY      = 2,
    parameter int LOCK_COUNT = 4,
    localparam int PW        = $clog2(2*DELAY+1)+1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IN,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic          locked,
    output logic          err,
    output logic          timeout
);

    localparam int GW = $clog2(LOCK_COUNT+1);

    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] DELAY_V = PW'(DELAY);
    localparam logic [GW-1:0] LOCK_V  = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [PW-1:0] period_q, period_d;
    logic          period_valid_q, period_valid_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic          timeout_q, timeout_d;

    logic          period_ok;
    logic [GW-1:0] good_inc;

    assign period_ok = (cnt_q == DELAY_V);
    assign good_inc  = good_q + 1'b1;

`ifdef PULSE_PERIOD_MONITOR_TIMEOUT_EN
    localparam logic [PW-1:0] TO_V = PW'(2*DELAY);
    logic to_hit;
    // A strobe on the timeout cycle wins: it is measured instead.
    assign to_hit = !IN && (state_q != IDLE) && (cnt_q == TO_V);
`endif

    always_comb begin
        state_d        = state_q;
        good_d         = good_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        err_d          = 1'b0;
        timeout_d      = 1'b0;

        if (IN)
            cnt_d = {{(PW-1){1'b0}}, 1'b1};
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (IN) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (IN) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (period_ok) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_V) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_d  = 1'b1;
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (IN) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (!period_ok) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        state_d  = ACQUIRE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef PULSE_PERIOD_MONITOR_TIMEOUT_EN
        if (to_hit) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            good_d    = '0;
            cnt_d     = '0;
            state_d   = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scoreboard bench for pulse_period_monitor: two instances (DELAY=4/LOCK=3 and
// DELAY=1/LOCK=2), directed strobe trains, queued expected output events.
module tb_pulse_period_monitor;

    typedef struct packed {
        logic       pv;
        logic [4:0] period;
        logic       err;
        logic       locked;
        logic       timeout;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in0, in1;
    logic [4:0] period0;
    logic       pv0, locked0, err0, to0;
    logic [2:0] period1;
    logic       pv1, locked1, err1, to1;

    int checks = 0;
    int errors = 0;

    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;

    pulse_period_monitor #(.DELAY(4), .LOCK_COUNT(3)) u0 (
        .clk(clk), .reset(reset), .IN(in0),
        .period(period0), .period_valid(pv0),
        .locked(locked0), .err(err0), .timeout(to0)
    );

    pulse_period_monitor #(.DELAY(1), .LOCK_COUNT(2)) u1 (
        .clk(clk), .reset(reset), .IN(in1),
        .period(period1), .period_valid(pv1),
        .locked(locked1), .err(err1), .timeout(to1)
    );

    function automatic ev_t mk(logic pv, int p, logic e, logic l, logic t);
        ev_t r;
        r.pv = pv;
        r.period = 5'(p);
        r.err = e;
        r.locked = l;
        r.timeout = t;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: every output event must match the head of its queue.
    always @(negedge clk) begin
        if (pv0 || err0 || to0) begin
            ev_t act;
            ev_t exp;
            act = mk(pv0, int'(period0), err0, locked0, to0);
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL u0_unexpected: got %b expected none", act);
            end else begin
                exp = q0.pop_front();
                if (act != exp) begin
                    errors++;
                    $display("FAIL u0_event: got %b expected %b", act, exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pv1 || err1 || to1) begin
            ev_t act;
            ev_t exp;
            act = mk(pv1, int'(period1), err1, locked1, to1);
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_unexpected: got %b expected none", act);
            end else begin
                exp = q1.pop_front();
                if (act != exp) begin
                    errors++;
                    $display("FAIL u1_event: got %b expected %b", act, exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Strobe on u0 'gap' edges after the previous one; optionally expect an event.
    task automatic send(int gap, bit ev, int p, bit e, bit l);
        for (int i = 0; i < gap - 1; i++) begin
            in0 = 1'b0;
            cyc();
        end
        if (ev) q0.push_back(mk(1'b1, p, e, l, 1'b0));
        in0 = 1'b1;
        cyc();
        in0 = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_period"}, int'(period0), 0);
        chk({tag, "_pv"}, int'(pv0), 0);
        chk({tag, "_locked"}, int'(locked0), 0);
        chk({tag, "_err"}, int'(err0), 0);
        chk({tag, "_timeout"}, int'(to0), 0);
    endtask

    initial begin
        reset = 1'b1;
        in0 = 1'b0;
        in1 = 1'b0;
        cyc();
        cyc();
        chk_zero("rst");
        chk("rst_u1_locked", int'(locked1), 0);
        chk("rst_u1_period", int'(period1), 0);
        reset = 1'b0;

        // Clean acquisition: reference, then three good periods lock.
        send(3, 0, 0, 0, 0);
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 1);
        chk("lock_after_4", int'(locked0), 1);
        send(4, 1, 4, 0, 1);

        // Short period while locked: err, unlock, relock after 3 good.
        send(3, 1, 3, 1, 0);
        chk("unlock_short", int'(locked0), 0);
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 1);
        chk("relock", int'(locked0), 1);

        // Long period while locked.
        send(6, 1, 6, 1, 0);
        send(4, 1, 4, 0, 0);

        // Reset while locked after getting back into lock.
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 1);
        reset = 1'b1;
        in0 = 1'b0;
        cyc();
        reset = 1'b0;
        chk_zero("midrst");
        send(5, 0, 0, 0, 0);
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 0);
        send(4, 1, 4, 0, 1);

        // Source stops.
`ifdef PULSE_PERIOD_MONITOR_TIMEOUT_EN
        q0.push_back(mk(1'b0, 4, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 12; i++) begin
            in0 = 1'b0;
            cyc();
        end
        chk("to_locked", int'(locked0), 0);
        send(1, 0, 0, 0, 0);
        send(4, 1, 4, 0, 0);
`else
        for (int i = 0; i < 50; i++) begin
            in0 = 1'b0;
            cyc();
            chk("stop_locked", int'(locked0), 1);
            chk("stop_timeout", int'(to0), 0);
        end
        send(10, 1, 31, 1, 0);
        send(4, 1, 4, 0, 0);
`endif

        // DELAY=1, LOCK_COUNT=2 with IN held high.
        repeat (3) cyc();
        q1.push_back(mk(1'b1, 1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            q1.push_back(mk(1'b1, 1, 1'b0, 1'b1, 1'b0));
        in1 = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("u1_locked_edge3", int'(locked1), 1);
        chk("u1_err_edge3", int'(err1), 0);
        cyc();
        cyc();
        cyc();
        in1 = 1'b0;
        repeat (4) cyc();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
